pcie_tlp_tx_arb: RTL and testbench
==================================

// Module: pcie_tlp_tx_arb
// PURPOSE
//  Packet-atomic round-robin arbiter merging NUM_CH application TLP streams onto one tx port toward the Data Link Layer.
//  Grants a channel on its SOP beat and holds the grant until that packet's EOP beat is accepted.
//  Registers the tx port through a skid buffer, so full throughput is kept under tx_ready backpressure.
//  Adds framing checks and a packet counter.
// PARAMETERS
//  NUM_CH            4    number of requesting channels (2..16)
//  DATA_WIDTH        256  payload beat width
//  TLP_HEADER_WIDTH  128  header width, carried on every beat and qualified by sop
//  MAX_BEATS         16   beats allowed per packet before err_len fires
// PORTS
//  clk          in   1                     clock, rising edge
//  rst          in   1                     reset, synchronous, active-high
//  ch_valid     in   NUM_CH                per-channel beat valid
//  ch_header    in   NUM_CH*TLP_HEADER_WIDTH  flattened headers, ch i at [i*HW +: HW]
//  ch_data      in   NUM_CH*DATA_WIDTH     flattened data, ch i at [i*DW +: DW]
//  ch_sop       in   NUM_CH                per-channel start of packet
//  ch_eop       in   NUM_CH                per-channel end of packet
//  ch_ready     out  NUM_CH                per-channel beat accept (one-hot or zero)
//  tx_valid     out  1                     output beat valid
//  tx_header    out  TLP_HEADER_WIDTH      output header
//  tx_data      out  DATA_WIDTH            output data
//  tx_sop       out  1                     output start of packet
//  tx_eop       out  1                     output end of packet
//  tx_ready     in   1                     DLL accepts beat
//  tx_ch        out  $clog2(NUM_CH)        source channel of current tx beat
//  err_framing  out  1                     1-cycle pulse on framing violation
//  err_len      out  1                     1-cycle pulse when beat count reaches MAX_BEATS+1
//  pkt_count    out  32                    packets fully forwarded, saturates at 0xFFFF_FFFF
// BEHAVIOUR
//  Reset values: tx_valid, tx_sop, tx_eop, err_* = 0; ch_ready = 0; pkt_count = 0; rr pointer = 0.
//  Reset clears the skid buffer and discards any in-flight beats.
//  Handshake rules:
//   - A beat transfers when valid & ready are high in the same cycle.
//   - tx_valid, once high, holds and the tx_* fields stay stable until tx_ready is high.
//   - ch_ready may depend on ch_valid combinationally; ch_valid must not depend on ch_ready.
//  FSM IDLE:
//   - Candidates are channels with ch_valid & ch_sop.
//   - Pick the first candidate at or after rr_ptr, wrapping modulo NUM_CH.
//   - ch_ready[g] = skid_can_accept, and the SOP beat is accepted that same cycle.
//   - On accept: rr_ptr <= g+1 (mod NUM_CH); beat_cnt <= 1.
//   - If the beat is not also EOP, go to PKT, else stay in IDLE.
//  FSM PKT:
//   - Only channel g is served: ch_ready[g] = skid_can_accept.
//   - Each accepted beat increments beat_cnt, saturating.
//   - Accepted EOP -> IDLE.
//   - No bubble between packets: arbitration runs in the cycle right after EOP.
//  Framing rules:
//   - In IDLE, a valid beat with sop=0 is never granted and does not block others; it waits.
//   - In PKT, a granted beat with sop=1 is forwarded and pulses err_framing.
//   - err_len pulses once, on the accepted beat where beat_cnt reaches MAX_BEATS+1; the packet continues.
//  Latency:
//   - 1 cycle from channel accept to tx_valid.
//   - Skid depth 2, so ch_ready stays high while tx_ready is high, giving 1 beat/cycle sustained.
//  pkt_count increments when a tx beat with tx_eop transfers; it holds at the maximum.
//  tx_ch travels with the beat through the skid buffer.
//  Simultaneous events:
//   - Several channels raise SOP in the same cycle: round-robin picks exactly one.
//   - EOP accepted and tx stalled in the same cycle: the FSM still returns to IDLE; the skid buffer holds the data.
//  Reset mid-packet: the FSM returns to IDLE and a partially sent packet is truncated. The upstream must also reset.
// STRUCTURE
//  pcie_tlp_pkg:
//   - typedef arb_state_e {IDLE, PKT}
//   - typedef tlp_beat_t {header, data, sop, eop, ch}
//   - default width constants, shared with pcie_intf users
//  Sub-module pcie_skid_buf:
//   - parametrised by payload width, 2 entries
//   - valid/ready on both sides, registered outputs
//  Arbiter logic and FSM live in this module; round-robin uses a masked-priority double-scan.
// TESTING
//  1) Reset held 3 cycles, ch_valid=4'b1111 -> tx_valid=0, ch_ready=0, pkt_count=0 throughout.
//  2) Ch0 and ch2 each send a 3-beat packet, both SOP in the same cycle, tx_ready=1
//     -> ch0 beats first, then ch2, 6 consecutive tx beats, no interleave, pkt_count=2.
//  3) All 4 channels stream 1-beat packets (sop=eop=1) continuously
//     -> grant order 0,1,2,3,0,... with 1 beat/cycle on tx.
//  4) Ch1 sends 4 beats while tx_ready toggles 1,0,0,1,...
//     -> no beat lost or duplicated, tx_* stable while stalled, tx_ch=1.
//  5) Ch3 sends beats 2..N with sop=1 mid-packet; separately, a 17-beat packet with MAX_BEATS=16
//     -> err_framing pulses once per bad beat; err_len pulses on beat 17 only.
//  6) Reset asserted during beat 2 of a 5-beat packet
//     -> next cycle tx_valid=0, FSM IDLE, rr_ptr=0, and the next SOP is granted normally.

Source files
------------

// File: rtl/pcie_tlp_pkg.sv
// Shared types and default widths for the TLP transmit path.
package pcie_tlp_pkg;

  localparam int unsigned NUM_CH_DEF           = 4;
  localparam int unsigned DATA_WIDTH_DEF       = 256;
  localparam int unsigned TLP_HEADER_WIDTH_DEF = 128;
  localparam int unsigned MAX_BEATS_DEF        = 16;
  localparam int unsigned CH_WIDTH_DEF         = $clog2(NUM_CH_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } arb_state_e;

  // One beat as it travels toward the Data Link Layer (default widths).
  typedef struct packed {
    logic [TLP_HEADER_WIDTH_DEF-1:0] header;
    logic [DATA_WIDTH_DEF-1:0]       data;
    logic                            sop;
    logic                            eop;
    logic [CH_WIDTH_DEF-1:0]         ch;
  } tlp_beat_t;

  // Flat width of a beat: header, data, sop, eop and source channel.
  function automatic int unsigned beat_width(input int unsigned hw, input int unsigned dw,
                                             input int unsigned cw);
    return hw + dw + 2 + cw;
  endfunction

endpackage

// File: rtl/pcie_skid_buf.sv
// Two-entry skid buffer: registered outputs, input ready driven purely from state.
module pcie_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             skid_valid_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             in_fire;
  logic             out_free;

  assign in_ready_o  = ~skid_valid_q;
  assign in_fire     = in_valid_i & ~skid_valid_q;
  assign out_free    = out_ready_i | ~out_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  // Occupancy: the skid slot fills only when the output stage is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      out_valid_q  <= skid_valid_q | in_fire;
      skid_valid_q <= 1'b0;
    end else if (in_fire) begin
      skid_valid_q <= 1'b1;
    end
  end

  // Payload: the skid entry drains first so beat order is preserved.
  always_ff @(posedge clk) begin
    if (out_free) begin
      if (skid_valid_q) begin
        out_data_q <= skid_data_q;
      end else if (in_fire) begin
        out_data_q <= in_data_i;
      end
    end else if (in_fire) begin
      skid_data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/pcie_tlp_tx_arb.sv
// Packet-atomic round-robin arbiter merging NUM_CH TLP streams onto one tx port.
module pcie_tlp_tx_arb
  import pcie_tlp_pkg::*;
#(
  parameter int unsigned NUM_CH           = NUM_CH_DEF,
  parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int unsigned TLP_HEADER_WIDTH = TLP_HEADER_WIDTH_DEF,
  parameter int unsigned MAX_BEATS        = MAX_BEATS_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CH-1:0]                  ch_valid,
  input  logic [NUM_CH*TLP_HEADER_WIDTH-1:0] ch_header,
  input  logic [NUM_CH*DATA_WIDTH-1:0]       ch_data,
  input  logic [NUM_CH-1:0]                  ch_sop,
  input  logic [NUM_CH-1:0]                  ch_eop,
  output logic [NUM_CH-1:0]                  ch_ready,
  output logic                               tx_valid,
  output logic [TLP_HEADER_WIDTH-1:0]        tx_header,
  output logic [DATA_WIDTH-1:0]              tx_data,
  output logic                               tx_sop,
  output logic                               tx_eop,
  input  logic                               tx_ready,
  output logic [$clog2(NUM_CH)-1:0]          tx_ch,
  output logic                               err_framing,
  output logic                               err_len,
  output logic [31:0]                        pkt_count
);

  localparam int unsigned CW  = $clog2(NUM_CH);
  localparam int unsigned PW  = beat_width(TLP_HEADER_WIDTH, DATA_WIDTH, CW);
  localparam int unsigned BCW = $clog2(MAX_BEATS + 2);
  localparam logic [BCW-1:0] LEN_LIMIT = BCW'(MAX_BEATS);
  localparam logic [CW-1:0]  LAST_CH   = CW'(NUM_CH - 1);

  arb_state_e      state_q, state_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   gnt_ch_q, gnt_ch_d;
  logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
  logic            err_framing_q, err_framing_d;
  logic            err_len_q, err_len_d;
  logic [31:0]     pkt_count_q;

  logic [TLP_HEADER_WIDTH-1:0] hdr_arr  [NUM_CH];
  logic [DATA_WIDTH-1:0]       data_arr [NUM_CH];
  logic [NUM_CH-1:0] cand, cand_masked, mask;
  logic [CW-1:0]     pick_ch;
  logic              pick_vld;
  logic [CW-1:0]     sel_ch;
  logic              sel_act, sel_sop, sel_eop, sel_fire, accept_ok;
  logic              skid_in_ready;
  logic [PW-1:0]     sel_payload, out_payload;
  logic              out_sop, out_eop;

  assign cand        = ch_valid & ch_sop;
  assign cand_masked = cand & mask;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign hdr_arr[gi]  = ch_header[gi*TLP_HEADER_WIDTH +: TLP_HEADER_WIDTH];
    assign data_arr[gi] = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign mask[gi]     = (CW'(gi) >= rr_ptr_q);
    assign ch_ready[gi] = accept_ok & (sel_ch == CW'(gi));
  end

  // Round-robin pick: lowest candidate at/after rr_ptr, else lowest overall.
  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pick_vld = 1'b1;
        pick_ch  = CW'(i);
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cand_masked[i]) begin
        pick_ch = CW'(i);
      end
    end
  end

  assign sel_ch      = (state_q == IDLE) ? pick_ch : gnt_ch_q;
  assign sel_act     = (state_q == IDLE) ? pick_vld : 1'b1;
  assign accept_ok   = ~rst & skid_in_ready & sel_act;
  assign sel_fire    = accept_ok & ch_valid[sel_ch];
  assign sel_sop     = ch_sop[sel_ch];
  assign sel_eop     = ch_eop[sel_ch];
  assign sel_payload = {hdr_arr[sel_ch], data_arr[sel_ch], sel_sop, sel_eop, sel_ch};

  // Next-state: grant on SOP in IDLE, hold the grant until the EOP beat is accepted.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_ch_d      = gnt_ch_q;
    beat_cnt_d    = beat_cnt_q;
    err_framing_d = 1'b0;
    err_len_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_fire) begin
          rr_ptr_d   = (sel_ch == LAST_CH) ? '0 : sel_ch + 1'b1;
          gnt_ch_d   = sel_ch;
          beat_cnt_d = BCW'(1);
          if (!sel_eop) state_d = PKT;
        end
      end
      PKT: begin
        if (sel_fire) begin
          if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 1'b1;
          err_len_d     = (beat_cnt_q == LEN_LIMIT);
          err_framing_d = sel_sop;
          if (sel_eop) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state and error pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      gnt_ch_q      <= '0;
      beat_cnt_q    <= '0;
      err_framing_q <= 1'b0;
      err_len_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_ch_q      <= gnt_ch_d;
      beat_cnt_q    <= beat_cnt_d;
      err_framing_q <= err_framing_d;
      err_len_q     <= err_len_d;
    end
  end

  // Forwarded-packet counter, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_q <= '0;
    end else if (tx_valid && tx_ready && tx_eop && (pkt_count_q != '1)) begin
      pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  pcie_skid_buf #(
    .WIDTH (PW)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (sel_fire),
    .in_data_i   (sel_payload),
    .in_ready_o  (skid_in_ready),
    .out_valid_o (tx_valid),
    .out_data_o  (out_payload),
    .out_ready_i (tx_ready)
  );

  assign {tx_header, tx_data, out_sop, out_eop, tx_ch} = out_payload;
  assign tx_sop      = tx_valid & out_sop;
  assign tx_eop      = tx_valid & out_eop;
  assign err_framing = err_framing_q;
  assign err_len     = err_len_q;
  assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_pcie_tlp_tx_arb.sv
// Bench for pcie_tlp_tx_arb: queued sources, packet-level round-robin model, per-cycle compare.
module tb_pcie_tlp_tx_arb;

  localparam int NCH  = 4;
  localparam int DW   = 256;
  localparam int HW   = 128;
  localparam int MAXB = 16;
  localparam int CW   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NCH-1:0]     ch_valid, ch_sop, ch_eop, ch_ready;
  logic [NCH*HW-1:0]  ch_header;
  logic [NCH*DW-1:0]  ch_data;
  logic               tx_valid, tx_sop, tx_eop, tx_ready;
  logic [HW-1:0]      tx_header;
  logic [DW-1:0]      tx_data;
  logic [CW-1:0]      tx_ch;
  logic               err_framing, err_len;
  logic [31:0]        pkt_count;

  always #5 clk = ~clk;

  pcie_tlp_tx_arb #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .TLP_HEADER_WIDTH(HW), .MAX_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_valid(ch_valid), .ch_header(ch_header), .ch_data(ch_data),
    .ch_sop(ch_sop), .ch_eop(ch_eop), .ch_ready(ch_ready),
    .tx_valid(tx_valid), .tx_header(tx_header), .tx_data(tx_data),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_ready(tx_ready), .tx_ch(tx_ch),
    .err_framing(err_framing), .err_len(err_len), .pkt_count(pkt_count)
  );

  typedef struct {
    logic [HW-1:0] hdr;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  typedef struct {
    logic [HW-1:0] hdr;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    int            ch;
    logic          frm;
    logic          len;
  } exp_t;

  beat_t src_q [NCH][$];
  beat_t mdl_q [NCH][$];
  exp_t  sb[$];
  int    ch_log[$];
  int    acc_cnt [NCH];

  int n_cmp = 0;
  int n_bad = 0;
  int mdl_ptr = 0;
  int mdl_pkts = 0;
  int cyc = 0;
  int tx_mode = 0;
  int tx_ph = 0;
  int frm_seen = 0, len_seen = 0;
  int xfer_n = 0, xfer_first = 0, xfer_last = 0;
  logic started = 1'b0;
  logic hold_all = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One source packet of n beats; bad=1 raises sop on every beat after the first.
  task automatic add_pkt(input int ch, input int n, input bit bad);
    beat_t b;
    for (int k = 1; k <= n; k++) begin
      b.hdr = {32'(ch), 32'(k), $urandom, $urandom};
      for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
      b.sop = (k == 1) || (bad && k > 1);
      b.eop = (k == n);
      src_q[ch].push_back(b);
      mdl_q[ch].push_back(b);
    end
  endtask

  // Packet-level round robin over every channel holding a pending packet.
  function automatic void build_expected();
    bit any;
    do begin
      any = 0;
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (mdl_ptr + k) % NCH;
        if (mdl_q[c].size() > 0) begin
          int idx;
          beat_t b;
          exp_t e;
          idx = 0;
          do begin
            b = mdl_q[c].pop_front();
            idx++;
            e.hdr = b.hdr; e.data = b.data; e.sop = b.sop; e.eop = b.eop; e.ch = c;
            e.frm = (idx > 1) && b.sop;
            e.len = (idx == MAXB + 1);
            sb.push_back(e);
          end while (!b.eop);
          mdl_ptr = (c + 1) % NCH;
          any = 1;
          break;
        end
      end
    end while (any);
  endfunction

  // One clock: apply reset effects to the model, drive inputs, record accepted beats.
  task automatic step(input bit rst_v);
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      mdl_ptr = 0;
      mdl_pkts = 0;
      sb.delete();
      for (int i = 0; i < NCH; i++) begin
        src_q[i].delete();
        mdl_q[i].delete();
      end
    end
    rst = rst_v;
    tx_ready = (tx_mode == 0) ? 1'b1 : ((tx_ph % 3) == 0);
    tx_ph++;
    for (int i = 0; i < NCH; i++) begin
      if (hold_all) begin
        ch_valid[i] = 1'b1; ch_sop[i] = 1'b1; ch_eop[i] = 1'b1;
        ch_header[i*HW +: HW] = '0; ch_data[i*DW +: DW] = '0;
      end else if (src_q[i].size() > 0) begin
        ch_valid[i] = 1'b1;
        ch_sop[i] = src_q[i][0].sop;
        ch_eop[i] = src_q[i][0].eop;
        ch_header[i*HW +: HW] = src_q[i][0].hdr;
        ch_data[i*DW +: DW] = src_q[i][0].data;
      end else begin
        ch_valid[i] = 1'b0; ch_sop[i] = 1'b0; ch_eop[i] = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (!hold_all && ch_valid[i] && ch_ready[i]) begin
        void'(src_q[i].pop_front());
        acc_cnt[i]++;
      end
    end
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (sb.size() > 0 && k < limit) begin
      step(1'b0);
      k++;
    end
    check("drain_left", 512'(sb.size()), 0);
    step(1'b0);
  endtask

  task automatic clear_log();
    ch_log.delete();
    xfer_n = 0;
    frm_seen = 0;
    len_seen = 0;
  endtask

  // Per-cycle compare of the tx port against the scoreboard.
  logic            prev_stall = 1'b0;
  logic [511:0]    prev_beat = '0;
  always @(negedge clk) begin : cmp
    logic [511:0] cur;
    exp_t         e;
    logic         xfer;
    if (started) begin
      cur  = 512'({tx_header, tx_data, tx_sop, tx_eop, tx_ch});
      xfer = tx_valid && tx_ready;
      check("ch_ready_onehot0", 512'($onehot0(ch_ready)), 1);
      check("pkt_count", 512'(pkt_count), 512'(mdl_pkts));
      if (prev_stall) begin
        check("stall_valid", 512'(tx_valid), 1);
        check("stall_stable", cur, prev_beat);
      end
      if (xfer) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 512'(xfer), 0);
        end else begin
          e = sb.pop_front();
          check("tx_beat", cur, 512'({e.hdr, e.data, e.sop, e.eop, CW'(e.ch)}));
          check("err_framing", 512'(err_framing), 512'(e.frm));
          check("err_len", 512'(err_len), 512'(e.len));
          if (e.eop) mdl_pkts++;
          $display("tx beat cyc=%0d ch=%0d sop=%0b eop=%0b", cyc, tx_ch, tx_sop, tx_eop);
        end
        ch_log.push_back(int'(tx_ch));
        xfer_n++;
        if (xfer_n == 1) xfer_first = cyc;
        xfer_last = cyc;
      end else begin
        check("err_framing_quiet", 512'(err_framing), 0);
        check("err_len_quiet", 512'(err_len), 0);
      end
      if (err_framing) frm_seen++;
      if (err_len) len_seen++;
      prev_stall = tx_valid && !tx_ready && !rst;
      prev_beat  = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t2_exp [6];
    int t3_exp [8];
    int t6_exp [4];
    int acc0;
    t2_exp = '{0, 0, 0, 2, 2, 2};
    t3_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
    t6_exp = '{1, 1, 3, 3};
    for (int i = 0; i < NCH; i++) acc_cnt[i] = 0;
    ch_valid = '0; ch_sop = '0; ch_eop = '0;
    ch_header = '0; ch_data = '0; tx_ready = 1'b1;

    // 1) reset held 3 cycles with every channel requesting
    hold_all = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      started = 1'b1;
      check("t1_tx_valid", 512'(tx_valid), 0);
      check("t1_ch_ready", 512'(ch_ready), 0);
      check("t1_pkt_count", 512'(pkt_count), 0);
    end
    hold_all = 1'b0;
    step(1'b0);
    step(1'b0);

    // 2) ch0 and ch2 3-beat packets, SOP together
    clear_log();
    add_pkt(0, 3, 0);
    add_pkt(2, 3, 0);
    build_expected();
    drain(100);
    check("t2_beats", 512'(ch_log.size()), 6);
    if (ch_log.size() == 6)
      for (int i = 0; i < 6; i++) check("t2_order", 512'(ch_log[i]), 512'(t2_exp[i]));
    check("t2_span", 512'(xfer_last - xfer_first), 5);
    check("t2_pkt_count", 512'(pkt_count), 2);

    // 3) all channels stream single-beat packets from a fresh pointer
    step(1'b1);
    step(1'b0);
    clear_log();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++) add_pkt(c, 1, 0);
    build_expected();
    drain(100);
    check("t3_beats", 512'(ch_log.size()), 8);
    if (ch_log.size() == 8)
      for (int i = 0; i < 8; i++) check("t3_order", 512'(ch_log[i]), 512'(t3_exp[i]));
    check("t3_span", 512'(xfer_last - xfer_first), 7);
    check("t3_pkt_count", 512'(pkt_count), 8);

    // 4) ch1 4 beats under tx_ready 1,0,0 backpressure
    clear_log();
    tx_mode = 1;
    tx_ph = 0;
    add_pkt(1, 4, 0);
    build_expected();
    drain(200);
    tx_mode = 0;
    step(1'b0);
    check("t4_beats", 512'(ch_log.size()), 4);
    for (int i = 0; i < ch_log.size(); i++) check("t4_tx_ch", 512'(ch_log[i]), 1);
    check("t4_pkt_count", 512'(pkt_count), 9);

    // 5) mid-packet SOPs on ch3, then a 17-beat packet on ch0
    clear_log();
    add_pkt(3, 5, 1);
    add_pkt(0, 17, 0);
    build_expected();
    drain(200);
    check("t5_framing_pulses", 512'(frm_seen), 4);
    check("t5_len_pulses", 512'(len_seen), 1);
    check("t5_beats", 512'(ch_log.size()), 22);
    if (ch_log.size() == 22) begin
      check("t5_first_ch", 512'(ch_log[0]), 3);
      check("t5_second_pkt_ch", 512'(ch_log[5]), 0);
    end
    check("t5_pkt_count", 512'(pkt_count), 11);

    // 6) reset during beat 2 of a 5-beat packet on ch2
    clear_log();
    add_pkt(2, 5, 0);
    build_expected();
    acc0 = acc_cnt[2];
    for (int k = 0; k < 20 && acc_cnt[2] == acc0; k++) step(1'b0);
    check("t6_beat1_accepted", 512'(acc_cnt[2] - acc0), 1);
    step(1'b1);
    step(1'b0);
    check("t6_tx_valid_after_rst", 512'(tx_valid), 0);
    check("t6_pkt_count_after_rst", 512'(pkt_count), 0);
    clear_log();
    add_pkt(3, 2, 0);
    add_pkt(1, 2, 0);
    build_expected();
    drain(100);
    check("t6_beats", 512'(ch_log.size()), 4);
    if (ch_log.size() == 4)
      for (int i = 0; i < 4; i++) check("t6_order", 512'(ch_log[i]), 512'(t6_exp[i]));
    check("t6_pkt_count", 512'(pkt_count), 2);

    step(1'b0);
    step(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
